pp_row_sequencer: RTL and testbench

- Sequential driver that sits directly upstream of the 4-to-16 row decoder in the Dadda multiplier datapath.
- Latches a multiplicand/multiplier pair on start, then steps a row index 0..WIDTH-1.
- Drives that index as the decoder select and emits one weighted partial-product row per index over a valid/ready handshake.
- Pulses done after the last row is accepted; feeds the reduction-tree input buffer.

---
 rtl/pp_row_sequencer.sv | 138 +++++++++++++
 tb/tb_pp_row_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_row_sequencer.sv
// pp_row_sequencer: latches a/b on start and steps a row index 0..WIDTH-1. For each index it drives
//   sel to the 4-to-16 row decoder and emits one weighted partial-product row over valid/ready.
// Latency: first row one cycle after start is sampled; back-to-back rows while row_ready_i=1; done one cycle after the last accept.
// Backpressure: an offered row, its index and sel hold until accepted. Build option PP_ROW_SKIP_ZERO_EN skips rows whose b bit is 0.
module pp_row_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [3:0]           sel_o,
    output logic                 row_valid_o,
    input  logic                 row_ready_i,
    output logic [2*WIDTH-1:0]   row_data_o,
    output logic [3:0]           row_idx_o,
    output logic                 busy_o,
    output logic                 done_o
);

`ifdef PP_ROW_SKIP_ZERO_EN
    // Rows whose multiplier bit is 0 are stepped over without a handshake.
    localparam logic SKIP_ZERO = 1'b1;
`else
    // Every row is offered, including all-zero ones.
    localparam logic SKIP_ZERO = 1'b0;
`endif

    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [3:0]           idx_q;
    logic [3:0]           sel_q;
    logic                 row_valid_q;
    logic [2*WIDTH-1:0]   row_data_q;
    logic [3:0]           row_idx_q;
    logic                 busy_q;
    logic                 done_q;

    logic [3:0]           idx_d;
    logic                 adv_d;

    // Partial-product row: a gated by one multiplier bit, shifted to that bit's weight.
    function automatic logic [2*WIDTH-1:0] row_of(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0]       idx);
        logic [2*WIDTH-1:0] ext;
        ext = {{WIDTH{1'b0}}, a & {WIDTH{b[idx]}}};
        return ext << idx;
    endfunction

    // Step decision: advance on a handshake, or unconditionally on a skipped (not offered) row.
    always_comb begin
        idx_d = idx_q + 4'd1;
        adv_d = row_valid_q ? row_ready_i : SKIP_ZERO;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            sel_q       <= '0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q     <= EMIT;
                        a_q         <= a_i;
                        b_q         <= b_i;
                        idx_q       <= '0;
                        sel_q       <= '0;
                        row_idx_q   <= '0;
                        row_valid_q <= b_i[0] | ~SKIP_ZERO;
                        row_data_q  <= row_of(a_i, b_i, 4'd0);
                        busy_q      <= 1'b1;
                    end
                end
                EMIT: begin
                    if (adv_d) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= DONE;
                            sel_q       <= '0;
                            row_idx_q   <= '0;
                            row_valid_q <= 1'b0;
                            row_data_q  <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q       <= idx_d;
                            sel_q       <= idx_d;
                            row_idx_q   <= idx_d;
                            row_valid_q <= b_q[idx_d] | ~SKIP_ZERO;
                            row_data_q  <= row_of(a_q, b_q, idx_d);
                        end
                    end
                end
                DONE: begin
                    // Start is not sampled here; it must be presented once back in IDLE.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    row_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o       = sel_q;
    assign row_valid_o = row_valid_q;
    assign row_data_o  = row_data_q;
    assign row_idx_o   = row_idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_pp_row_sequencer.sv
// Bench for pp_row_sequencer (WIDTH=16): a scoreboard queue holds expected rows per start.
// Cycle-timed checks cover sel/row_valid/done/busy; handshakes pop and compare rows.
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_pp_row_sequencer;

    localparam int W = 16;
`ifdef PP_ROW_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic [3:0]    sel;
    logic          row_valid;
    logic          row_ready;
    logic [2*W-1:0] row_data;
    logic [3:0]    row_idx;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int hs       = 0;
    logic [35:0] sb[$];

    always #5 clk = ~clk;

    pp_row_sequencer #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .a_i         (a_in),
        .b_i         (b_in),
        .sel_o       (sel),
        .row_valid_o (row_valid),
        .row_ready_i (row_ready),
        .row_data_o  (row_data),
        .row_idx_o   (row_idx),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observe this cycle's handshake (inputs already set), then advance one clock.
    task automatic tick();
        logic [35:0] e;
        if (row_valid === 1'b1 && row_ready === 1'b1) begin
            hs++;
            chk("row_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("row_idx_%0d", e[35:32]), 64'(row_idx), 64'(e[35:32]));
                chk($sformatf("row_data_%0d", e[35:32]), 64'(row_data), 64'(e[31:0]));
                chk($sformatf("row_sel_%0d", e[35:32]), 64'(sel), 64'(e[35:32]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_rows(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (!SKIP || b[i]) begin
                r = {16'h0000, (b[i] ? a : 16'h0000)};
                r = r << i;
                sb.push_back({4'(i), r});
            end
        end
    endtask

    // Start an operation with ready held high and check per-cycle timing against the start cycle.
    task automatic run_basic(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int exp_hs;
        logic v;
        a_in = a; b_in = b; start = 1'b1; row_ready = 1'b1;
        push_rows(a, b);
        hs = 0;
        tick();
        start = 1'b0;
        exp_hs = SKIP ? $countones(b) : W;
        for (int k = 1; k <= W + 2; k++) begin
            v = 1'b0;
            if (k <= W) v = !SKIP || b[k-1];
            chk($sformatf("%s_valid_c%0d", tag, k), 64'(row_valid), 64'(v));
            chk($sformatf("%s_sel_c%0d", tag, k), 64'(sel), (k <= W) ? 64'(k - 1) : 64'd0);
            chk($sformatf("%s_done_c%0d", tag, k), 64'(done), 64'(k == W + 1));
            chk($sformatf("%s_busy_c%0d", tag, k), 64'(busy), 64'(k <= W + 1));
            tick();
        end
        chk({tag, "_handshakes"}, 64'(hs), 64'(exp_hs));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idx(input string tag, input logic [3:0] target);
        int g = 0;
        while (row_idx !== target && g < 64) begin
            tick();
            g++;
        end
        chk({tag, "_reach_idx"}, 64'(g < 64), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (done !== 1'b1 && g < 64) begin
            tick();
            g++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; row_ready = 1'b0;
        tick();
        tick();
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_valid", 64'(row_valid), 64'd0);
        chk("rst_data", 64'(row_data), 64'd0);
        chk("rst_idx", 64'(row_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Main function, sparse multiplier, and skip-specific patterns.
        run_basic("ff_5", 16'h00FF, 16'h0005);
        run_basic("ff_8001", 16'h00FF, 16'h8001);
        run_basic("zero", 16'h0000, 16'h0000);
        run_basic("mix", 16'hA5C3, 16'h7E19);

        // Backpressure at idx 5: row, index and sel hold for 3 stalled cycles.
        a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1; row_ready = 1'b1;
        push_rows(16'hFFFF, 16'hFFFF);
        tick();
        start = 1'b0;
        wait_idx("stall", 4'd5);
        row_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("stall_valid_%0d", s), 64'(row_valid), 64'd1);
            chk($sformatf("stall_sel_%0d", s), 64'(sel), 64'd5);
            chk($sformatf("stall_idx_%0d", s), 64'(row_idx), 64'd5);
            chk($sformatf("stall_data_%0d", s), 64'(row_data), 64'h001FFFE0);
            if (s == 3) row_ready = 1'b1;
            tick();
        end
        chk("stall_next_idx", 64'(row_idx), 64'd6);
        chk("stall_next_data", 64'(row_data), 64'h003FFFC0);
        wait_done("stall");
        tick();
        chk("stall_idle_busy", 64'(busy), 64'd0);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of an operation abandons it with no done pulse.
        a_in = 16'hABCD; b_in = 16'hFFFF; start = 1'b1; row_ready = 1'b1;
        push_rows(16'hABCD, 16'hFFFF);
        tick();
        start = 1'b0;
        wait_idx("midrst", 4'd7);
        row_ready = 1'b0;
        rst = 1'b1;
        tick();
        sb.delete();
        rst = 1'b0;
        chk("midrst_sel", 64'(sel), 64'd0);
        chk("midrst_valid", 64'(row_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_data", 64'(row_data), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        run_basic("fresh", 16'h0003, 16'h0003);

        // Start while busy is ignored; remaining rows use the original operands.
        a_in = 16'h00F0; b_in = 16'h00FF; start = 1'b1; row_ready = 1'b1;
        push_rows(16'h00F0, 16'h00FF);
        tick();
        start = 1'b0;
        tick();
        tick();
        a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0; a_in = '0; b_in = '0;
        wait_done("ignore");
        tick();
        chk("ignore_idle_busy", 64'(busy), 64'd0);
        chk("ignore_sb_empty", 64'(sb.size()), 64'd0);
        chk("ignore_idle_valid", 64'(row_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
